// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-requester external bus arbiter (fetch vs data) with starvation guard
// Data accesses win contention until starve_q reaches STARVE_LIMIT, then one fetch is forced through.
module bus_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fetch_valid,
    input  logic [ADDR_WIDTH-1:0] fetch_address,
    input  logic                  fetch_flush,
    output logic                  fetch_ready,
    output logic [DATA_WIDTH-1:0] fetch_data,
    input  logic                  data_valid,
    input  logic                  data_write_enable,
    input  logic [ADDR_WIDTH-1:0] data_address,
    input  logic [DATA_WIDTH-1:0] data_write_data,
    output logic                  data_ready,
    output logic [DATA_WIDTH-1:0] data_read_data,
    output logic                  bus_vaild,
    input  logic                  bus_ready,
    output logic                  bus_write_enable,
    output logic [ADDR_WIDTH-1:0] bus_address,
    output logic [DATA_WIDTH-1:0] bus_write_data,
    input  logic [DATA_WIDTH-1:0] bus_data,
    output logic [1:0]            grant_owner
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [1:0] OWN_NONE  = 2'b00;
    localparam logic [1:0] OWN_FETCH = 2'b01;
    localparam logic [1:0] OWN_DATA  = 2'b10;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]            state_q, state_d;
    logic [3:0]            starve_q, starve_d;
    logic                  flush_pending_q, flush_pending_d;
    logic                  fetch_ready_q, fetch_ready_d;
    logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
    logic                  data_ready_q, data_ready_d;
    logic [DATA_WIDTH-1:0] data_read_data_q, data_read_data_d;
    logic                  bus_vaild_q, bus_vaild_d;
    logic                  bus_write_enable_q, bus_write_enable_d;
    logic [ADDR_WIDTH-1:0] bus_address_q, bus_address_d;
    logic [DATA_WIDTH-1:0] bus_write_data_q, bus_write_data_d;
    logic [1:0]            grant_owner_q, grant_owner_d;

    logic fetch_req;
    logic grant_data;
    logic grant_fetch;

    // A fetch being flushed this cycle is not a candidate for the grant.
    assign fetch_req   = fetch_valid & ~fetch_flush;
    assign grant_data  = data_valid & (~fetch_req | (starve_q < LIMIT));
    assign grant_fetch = fetch_req & ~grant_data;

    always_comb begin
        state_d            = state_q;
        starve_d           = starve_q;
        flush_pending_d    = flush_pending_q;
        fetch_ready_d      = 1'b0;
        fetch_data_d       = fetch_data_q;
        data_ready_d       = 1'b0;
        data_read_data_d   = data_read_data_q;
        bus_vaild_d        = bus_vaild_q;
        bus_write_enable_d = bus_write_enable_q;
        bus_address_d      = bus_address_q;
        bus_write_data_d   = bus_write_data_q;
        grant_owner_d      = grant_owner_q;

        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d            = BUS;
                    bus_vaild_d        = 1'b1;
                    bus_write_enable_d = data_write_enable;
                    bus_address_d      = data_address;
                    bus_write_data_d   = data_write_data;
                    grant_owner_d      = OWN_DATA;
                    if (fetch_valid) begin
                        starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;
                    end else begin
                        starve_d = 4'd0;
                    end
                end else if (grant_fetch) begin
                    state_d            = BUS;
                    bus_vaild_d        = 1'b1;
                    bus_write_enable_d = 1'b0;
                    bus_address_d      = fetch_address;
                    bus_write_data_d   = '0;
                    grant_owner_d      = OWN_FETCH;
                    starve_d           = 4'd0;
                end
            end
            BUS: begin
                if ((grant_owner_q == OWN_FETCH) && fetch_flush) begin
                    flush_pending_d = 1'b1;
                end
                if (bus_ready) begin
                    state_d     = RESP;
                    bus_vaild_d = 1'b0;
                    if (grant_owner_q == OWN_DATA) begin
                        data_ready_d = 1'b1;
                        if (!bus_write_enable_q) begin
                            data_read_data_d = bus_data;
                        end
                    end else if (!(flush_pending_q || fetch_flush)) begin
                        // A flushed fetch still completes on the bus but is never returned.
                        fetch_ready_d = 1'b1;
                        fetch_data_d  = bus_data;
                    end
                end
            end
            RESP: begin
                state_d         = IDLE;
                grant_owner_d   = OWN_NONE;
                flush_pending_d = 1'b0;
            end
            default: begin
                state_d       = IDLE;
                bus_vaild_d   = 1'b0;
                grant_owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q            <= IDLE;
            starve_q           <= 4'd0;
            flush_pending_q    <= 1'b0;
            fetch_ready_q      <= 1'b0;
            fetch_data_q       <= '0;
            data_ready_q       <= 1'b0;
            data_read_data_q   <= '0;
            bus_vaild_q        <= 1'b0;
            bus_write_enable_q <= 1'b0;
            bus_address_q      <= '0;
            bus_write_data_q   <= '0;
            grant_owner_q      <= OWN_NONE;
        end else begin
            state_q            <= state_d;
            starve_q           <= starve_d;
            flush_pending_q    <= flush_pending_d;
            fetch_ready_q      <= fetch_ready_d;
            fetch_data_q       <= fetch_data_d;
            data_ready_q       <= data_ready_d;
            data_read_data_q   <= data_read_data_d;
            bus_vaild_q        <= bus_vaild_d;
            bus_write_enable_q <= bus_write_enable_d;
            bus_address_q      <= bus_address_d;
            bus_write_data_q   <= bus_write_data_d;
            grant_owner_q      <= grant_owner_d;
        end
    end

    assign fetch_ready      = fetch_ready_q;
    assign fetch_data       = fetch_data_q;
    assign data_ready       = data_ready_q;
    assign data_read_data   = data_read_data_q;
    assign bus_vaild        = bus_vaild_q;
    assign bus_write_enable = bus_write_enable_q;
    assign bus_address      = bus_address_q;
    assign bus_write_data   = bus_write_data_q;
    assign grant_owner      = grant_owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed and randomized self-checking bench for bus_arbiter
module tb_bus_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clock;
    logic          reset;
    logic          fetch_valid;
    logic [AW-1:0] fetch_address;
    logic          fetch_flush;
    logic          fetch_ready;
    logic [DW-1:0] fetch_data;
    logic          data_valid;
    logic          data_write_enable;
    logic [AW-1:0] data_address;
    logic [DW-1:0] data_write_data;
    logic          data_ready;
    logic [DW-1:0] data_read_data;
    logic          bus_vaild;
    logic          bus_ready;
    logic          bus_write_enable;
    logic [AW-1:0] bus_address;
    logic [DW-1:0] bus_write_data;
    logic [DW-1:0] bus_data;
    logic [1:0]    grant_owner;

    bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_address(fetch_address), .fetch_flush(fetch_flush),
        .fetch_ready(fetch_ready), .fetch_data(fetch_data),
        .data_valid(data_valid), .data_write_enable(data_write_enable),
        .data_address(data_address), .data_write_data(data_write_data),
        .data_ready(data_ready), .data_read_data(data_read_data),
        .bus_vaild(bus_vaild), .bus_ready(bus_ready), .bus_write_enable(bus_write_enable),
        .bus_address(bus_address), .bus_write_data(bus_write_data), .bus_data(bus_data),
        .grant_owner(grant_owner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int m_starve = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    // Arbitration rule as a transaction-level model: returns the owner a grant should pick.
    function automatic logic [1:0] predict(input logic fv, input logic dv);
        if (dv && (!fv || m_starve < LIMIT)) begin
            if (fv) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
            else    m_starve = 0;
            return 2'b10;
        end
        if (fv) begin
            m_starve = 0;
            return 2'b01;
        end
        return 2'b00;
    endfunction

    task automatic step();
        @(negedge clock);
    endtask

    logic pv_inv = 1'b0;
    always @(negedge clock) begin
        check("ready_exclusive", {63'd0, fetch_ready & data_ready}, 64'd0);
        check("vaild_rise_on_ready", {63'd0, bus_vaild & ~pv_inv & (fetch_ready | data_ready)}, 64'd0);
        pv_inv <= bus_vaild;
    end

    logic [1:0]    cont_seq [10];
    logic [1:0]    exp_owner, cur_owner, resp_owner;
    logic [AW-1:0] exp_addr, cur_addr, f_addr, d_addr;
    logic [DW-1:0] exp_wdata, d_wdata, resp_data, last_rd, old_fd;
    logic          exp_we, cur_we, resp_we, d_we;
    logic          exp_grant, exp_resp, f_act, d_act, in_bus;
    int            k, cnt, pulses, grants, first_pulse, gap;

    initial begin
        reset = 1'b0; fetch_valid = 0; fetch_address = '0; fetch_flush = 0;
        data_valid = 0; data_write_enable = 0; data_address = '0; data_write_data = '0;
        bus_ready = 0; bus_data = '0;
        step(); step();
        check("rst_vaild", {63'd0, bus_vaild}, 0);
        check("rst_owner", {62'd0, grant_owner}, 0);
        check("rst_readies", {62'd0, fetch_ready, data_ready}, 0);
        check("rst_buses", {bus_address, bus_write_data}, 0);
        check("rst_rdata", {fetch_data, data_read_data}, 0);
        check("rst_we", {63'd0, bus_write_enable}, 0);
        reset = 1'b1;
        step();

        // Single fetch, bus_ready on the second BUS cycle.
        fetch_valid = 1; fetch_address = 32'h0000FFF0;
        step();
        check("sf_vaild", {63'd0, bus_vaild}, 1);
        check("sf_addr", bus_address, 32'h0000FFF0);
        check("sf_we", {63'd0, bus_write_enable}, 0);
        check("sf_owner", {62'd0, grant_owner}, 2'b01);
        void'(predict(1, 0));
        step();
        check("sf_hold", {bus_vaild, bus_address}, {1'b1, 32'h0000FFF0});
        check("sf_noready_early", {63'd0, fetch_ready}, 0);
        bus_ready = 1; bus_data = 32'hEA5B00F0;
        step();
        check("sf_ready", {63'd0, fetch_ready}, 1);
        check("sf_data", fetch_data, 32'hEA5B00F0);
        check("sf_owner_resp", {62'd0, grant_owner}, 2'b01);
        fetch_valid = 0; bus_ready = 0;
        step();
        check("sf_ready_drop", {63'd0, fetch_ready}, 0);
        check("sf_owner_none", {62'd0, grant_owner}, 0);

        // Data write with immediate bus_ready.
        data_valid = 1; data_write_enable = 1; data_address = 32'h100;
        data_write_data = 32'hDEADBEEF; bus_ready = 1; bus_data = 32'h0BAD0BAD;
        step();
        check("dw_owner", {62'd0, grant_owner}, 2'b10);
        check("dw_bus", {bus_write_enable, bus_address, bus_write_data}, {1'b1, 32'h100, 32'hDEADBEEF});
        void'(predict(0, 1));
        step();
        check("dw_ready", {63'd0, data_ready}, 1);
        check("dw_rdata_kept", data_read_data, 0);
        data_valid = 0; bus_ready = 0;
        step();
        check("dw_ready_drop", {63'd0, data_ready}, 0);

        // Contention: both requesters held, immediate bus_ready.
        cont_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        fetch_valid = 1; fetch_address = 32'h2000;
        data_valid = 1; data_write_enable = 0; data_address = 32'h3000;
        bus_ready = 1; bus_data = 32'h11112222;
        k = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus_vaild) begin
                check($sformatf("cont_grant_%0d", k), {62'd0, grant_owner}, {62'd0, cont_seq[k]});
                void'(predict(1, 1));
                k++;
                if (k == 10) begin
                    fetch_valid = 0; data_valid = 0;
                    break;
                end
            end
        end
        check("cont_count", k, 10);
        step(); step();
        bus_ready = 0;

        // Flush while the fetch owns the bus.
        old_fd = fetch_data;
        fetch_valid = 1; fetch_address = 32'h4440;
        step();
        check("fl_owner", {62'd0, grant_owner}, 2'b01);
        void'(predict(1, 0));
        fetch_flush = 1; fetch_valid = 0;
        data_valid = 1; data_write_enable = 0; data_address = 32'h200;
        step();
        fetch_flush = 0;
        check("fl_hold1", {63'd0, bus_vaild}, 1);
        step();
        check("fl_hold2", {63'd0, bus_vaild}, 1);
        step();
        check("fl_hold3", {bus_vaild, bus_address}, {1'b1, 32'h4440});
        bus_ready = 1; bus_data = 32'h12345678;
        step();
        check("fl_no_ready", {62'd0, fetch_ready, data_ready}, 0);
        check("fl_fdata_kept", fetch_data, old_fd);
        check("fl_vaild_low", {63'd0, bus_vaild}, 0);
        bus_ready = 0;
        step();
        check("fl_idle_owner", {62'd0, grant_owner}, 0);
        step();
        exp_owner = predict(0, 1);
        check("fl_next_grant", {bus_vaild, grant_owner, bus_address}, {1'b1, exp_owner, 32'h200});
        bus_ready = 1; bus_data = 32'h87654321;
        step();
        check("fl_data_ready", {63'd0, data_ready}, 1);
        check("fl_rdata", data_read_data, 32'h87654321);
        data_valid = 0; bus_ready = 0;
        step();

        // Reset in the middle of a bus transaction.
        data_valid = 1; data_write_enable = 1; data_address = 32'h300; data_write_data = 32'h3;
        step();
        check("rm_vaild", {63'd0, bus_vaild}, 1);
        reset = 0; data_valid = 0;
        step();
        m_starve = 0;
        check("rm_after", {bus_vaild, grant_owner, fetch_ready, data_ready}, 0);
        check("rm_rdata", data_read_data, 0);
        reset = 1; bus_ready = 1; bus_data = 32'hFFFF0000;
        step();
        check("rm_ignored1", {bus_vaild, fetch_ready, data_ready}, 0);
        step();
        check("rm_ignored2", {bus_vaild, fetch_ready, data_ready}, 0);
        bus_ready = 0;
        fetch_valid = 1; fetch_address = 32'h400;
        step();
        exp_owner = predict(1, 0);
        check("rm_new_grant", {bus_vaild, grant_owner, bus_address}, {1'b1, exp_owner, 32'h400});
        bus_ready = 1; bus_data = 32'h0000CAFE;
        step();
        check("rm_new_ready", {fetch_ready, fetch_data}, {1'b1, 32'h0000CAFE});
        fetch_valid = 0; bus_ready = 0;
        step();

        // Back-to-back reads from the data requester.
        data_valid = 1; data_write_enable = 0; data_address = 32'h500;
        bus_ready = 1; bus_data = 32'h5555AAAA;
        pulses = 0; grants = 0; first_pulse = 0; gap = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (data_ready) begin
                if (pulses == 0) first_pulse = c;
                else gap = c - first_pulse;
                pulses++;
            end
            if (bus_vaild) begin
                grants++;
                void'(predict(0, 1));
                if (grants == 2) data_valid = 0;
            end
        end
        check("b2b_pulses", pulses, 2);
        check("b2b_gap_ge3", {63'd0, gap >= 3}, 1);
        bus_ready = 0;

        // Randomized traffic against the transaction-level model.
        reset = 0; step(); step(); reset = 1;
        m_starve = 0; last_rd = '0;
        f_act = 0; d_act = 0; exp_grant = 0; exp_resp = 0; in_bus = 0; cnt = 0;
        cur_owner = 0; cur_addr = '0; cur_we = 0; resp_owner = 0; resp_data = '0; resp_we = 0;
        exp_owner = 0; exp_addr = '0; exp_we = 0; exp_wdata = '0;
        f_addr = '0; d_addr = '0; d_we = 0; d_wdata = '0;
        for (int c = 0; c < 600; c++) begin
            step();
            if (exp_grant) begin
                check("rnd_grant", {bus_vaild, grant_owner, bus_address, bus_write_enable},
                      {1'b1, exp_owner, exp_addr, exp_we});
                if (exp_owner == 2'b10 && exp_we) check("rnd_wdata", bus_write_data, exp_wdata);
                cnt = $urandom_range(0, 3);
                cur_owner = exp_owner; cur_addr = exp_addr; cur_we = exp_we;
            end else begin
                check("rnd_unexpected_grant", {63'd0, bus_vaild & ~in_bus}, 0);
            end
            if (in_bus && bus_vaild)
                check("rnd_stable", {bus_address, bus_write_enable}, {cur_addr, cur_we});
            if (exp_resp) begin
                if (resp_owner == 2'b01) begin
                    check("rnd_fetch_resp", {fetch_ready, data_ready, fetch_data}, {2'b10, resp_data});
                end else begin
                    if (!resp_we) last_rd = resp_data;
                    check("rnd_data_resp", {fetch_ready, data_ready, data_read_data}, {2'b01, last_rd});
                end
            end else begin
                check("rnd_no_ready", {62'd0, fetch_ready, data_ready}, 0);
            end
            in_bus = bus_vaild;

            if (fetch_ready) f_act = 0;
            if (data_ready)  d_act = 0;
            if (!f_act && ($urandom_range(0, 1) == 1)) begin
                f_act = 1; f_addr = $urandom;
            end
            if (!d_act && ($urandom_range(0, 1) == 1)) begin
                d_act = 1; d_addr = $urandom; d_we = $urandom_range(0, 1) == 1; d_wdata = $urandom;
            end
            fetch_valid = f_act; fetch_address = f_addr;
            data_valid = d_act; data_address = d_addr;
            data_write_enable = d_we; data_write_data = d_wdata;

            exp_grant = (grant_owner == 2'b00) && (f_act || d_act);
            if (exp_grant) begin
                exp_owner = predict(f_act, d_act);
                exp_addr  = (exp_owner == 2'b10) ? d_addr : f_addr;
                exp_we    = (exp_owner == 2'b10) ? d_we : 1'b0;
                exp_wdata = d_wdata;
            end

            exp_resp = 0;
            bus_data = $urandom;
            if (bus_vaild) begin
                if (cnt == 0) begin
                    bus_ready = 1; exp_resp = 1;
                    resp_owner = cur_owner; resp_data = bus_data; resp_we = cur_we;
                end else begin
                    cnt--; bus_ready = 0;
                end
            end else begin
                bus_ready = $urandom_range(0, 3) == 0;
            end
        end
        fetch_valid = 0; data_valid = 0; bus_ready = 0;
        step(); step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
